sram_controller: RTL

Downstream neighbour of the processor cache. Consumes the cache's word-wide RAM request interface (level request, one-cycle done pulse) and performs each 32-bit access as two 16-bit accesses on an external asynchronous SRAM with programmable wait states. Each request is registered at acceptance, so the cache may change address/data freely once it sees the done pulse.

---
 rtl/sram_controller.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/sram_controller.sv
// Cache-side 32-bit word requests served as two 16-bit accesses on an asynchronous SRAM.
// Optional macro SRAM_TURNAROUND_EN: one idle bus cycle whenever the access direction changes.
module sram_controller #(
  parameter int ADDRBITS   = 20,
  parameter int WAITCYCLES = 2
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                RAMSchreiben,
  input  logic                RAMLesen,
  input  logic [31:0]         RAMAdresse,
  input  logic [31:0]         RAMSchreibDaten,
  output logic [31:0]         RAMLesDaten,
  output logic                RAMDatenGeschrieben,
  output logic                RAMDatenGelesen,
  output logic [ADDRBITS-1:0] SramAdresse,
  output logic [15:0]         SramDatenAus,
  input  logic [15:0]         SramDatenEin,
  output logic                SramDatenOE,
  output logic                SramCE_n,
  output logic                SramWE_n,
  output logic                SramOE_n,
  output logic                SramLB_n,
  output logic                SramUB_n,
  output logic [2:0]          DbgState_o
);

  localparam int PW = $clog2(WAITCYCLES + 3);
  localparam int WB = ADDRBITS - 1;
  localparam logic [PW-1:0] RD_LAST = PW'(WAITCYCLES);
  localparam logic [PW-1:0] WR_LAST = PW'(WAITCYCLES + 2);

  typedef enum logic [2:0] {
    IDLE, READ_LO, READ_HI, WRITE_LO, WRITE_HI, DONE
`ifdef SRAM_TURNAROUND_EN
    , TURNAROUND
`endif
  } state_t;

  state_t          state_q;
  logic [PW-1:0]   phase_q;
  logic            wr_q;
  logic [WB-1:0]   word_q;
  logic [31:0]     wdata_q;
  logic [15:0]     lo_q;
`ifdef SRAM_TURNAROUND_EN
  logic            last_wr_q;
`endif

  logic            req;
  logic            start_now;
  logic            start_wr;
  logic [WB-1:0]   start_word;
  logic [31:0]     start_wdata;
  logic            unused_addr_bits;

  assign unused_addr_bits = ^RAMAdresse[31:WB];
  assign DbgState_o       = state_q;
  assign req              = RAMSchreiben | RAMLesen;

  // Launch parameters come straight from the request in IDLE, from the latched copy after a turnaround.
  always_comb begin
    start_now   = 1'b0;
    start_wr    = wr_q;
    start_word  = word_q;
    start_wdata = wdata_q;
    if (state_q == IDLE) begin
      start_wr    = RAMSchreiben;
      start_word  = RAMAdresse[WB-1:0];
      start_wdata = RAMSchreibDaten;
      start_now   = req;
`ifdef SRAM_TURNAROUND_EN
      if (RAMSchreiben != last_wr_q) start_now = 1'b0;
    end else if (state_q == TURNAROUND) begin
      start_now = 1'b1;
`endif
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q             <= IDLE;
      phase_q             <= '0;
      wr_q                <= 1'b0;
      word_q              <= '0;
      wdata_q             <= '0;
      lo_q                <= '0;
      RAMLesDaten         <= '0;
      RAMDatenGelesen     <= 1'b0;
      RAMDatenGeschrieben <= 1'b0;
      SramAdresse         <= '0;
      SramDatenAus        <= '0;
      SramDatenOE         <= 1'b0;
      SramCE_n            <= 1'b1;
      SramWE_n            <= 1'b1;
      SramOE_n            <= 1'b1;
      SramLB_n            <= 1'b1;
      SramUB_n            <= 1'b1;
`ifdef SRAM_TURNAROUND_EN
      last_wr_q           <= 1'b0;
`endif
    end else begin
      RAMDatenGelesen     <= 1'b0;
      RAMDatenGeschrieben <= 1'b0;
      phase_q             <= phase_q + PW'(1);
      case (state_q)
        IDLE: begin
          if (req) begin
            wr_q    <= RAMSchreiben;
            word_q  <= RAMAdresse[WB-1:0];
            wdata_q <= RAMSchreibDaten;
`ifdef SRAM_TURNAROUND_EN
            // Overridden below when no direction change is involved.
            state_q <= TURNAROUND;
            phase_q <= '0;
`endif
          end
        end
`ifdef SRAM_TURNAROUND_EN
        TURNAROUND: ;
`endif
        READ_LO: begin
          if (phase_q == RD_LAST) begin
            lo_q        <= SramDatenEin;
            state_q     <= READ_HI;
            phase_q     <= '0;
            SramAdresse <= {word_q, 1'b1};
          end
        end
        READ_HI: begin
          if (phase_q == RD_LAST) begin
            RAMLesDaten     <= {SramDatenEin, lo_q};
            RAMDatenGelesen <= 1'b1;
            state_q         <= DONE;
            phase_q         <= '0;
            SramCE_n        <= 1'b1;
            SramWE_n        <= 1'b1;
            SramOE_n        <= 1'b1;
            SramLB_n        <= 1'b1;
            SramUB_n        <= 1'b1;
            SramDatenOE     <= 1'b0;
`ifdef SRAM_TURNAROUND_EN
            last_wr_q       <= 1'b0;
`endif
          end
        end
        WRITE_LO: begin
          if (phase_q == WR_LAST) begin
            state_q      <= WRITE_HI;
            phase_q      <= '0;
            SramAdresse  <= {word_q, 1'b1};
            SramDatenAus <= wdata_q[31:16];
            SramWE_n     <= 1'b1;
          end else begin
            // WE_n low from phase 1 up to, but not including, the hold phase.
            SramWE_n <= (phase_q + PW'(1) == WR_LAST);
          end
        end
        WRITE_HI: begin
          if (phase_q == WR_LAST) begin
            RAMDatenGeschrieben <= 1'b1;
            state_q             <= DONE;
            phase_q             <= '0;
            SramCE_n            <= 1'b1;
            SramWE_n            <= 1'b1;
            SramOE_n            <= 1'b1;
            SramLB_n            <= 1'b1;
            SramUB_n            <= 1'b1;
            SramDatenOE         <= 1'b0;
`ifdef SRAM_TURNAROUND_EN
            last_wr_q           <= 1'b1;
`endif
          end else begin
            SramWE_n <= (phase_q + PW'(1) == WR_LAST);
          end
        end
        DONE: begin
          state_q <= IDLE;
          phase_q <= '0;
        end
        default: begin
          state_q <= IDLE;
          phase_q <= '0;
        end
      endcase

      if (start_now) begin
        state_q      <= start_wr ? WRITE_LO : READ_LO;
        phase_q      <= '0;
        SramAdresse  <= {start_word, 1'b0};
        SramDatenAus <= start_wdata[15:0];
        SramDatenOE  <= start_wr;
        SramCE_n     <= 1'b0;
        SramWE_n     <= 1'b1;
        SramOE_n     <= start_wr;
        SramLB_n     <= 1'b0;
        SramUB_n     <= 1'b0;
      end
    end
  end

endmodule
